// File: rtl/hazard_scoreboard_if.sv
// Operand-hazard bus between the ID stage and the hazard scoreboard.
// The master side drives issue/read requests; the slave side returns stall and forwarding.
interface hazard_scoreboard_if #(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic                     en;
  logic                     flush;
  logic                     iss_wen;
  logic [TAG_W-1:0]         iss_dst;
  logic                     iss_load;
  logic [NUM_RD*TAG_W-1:0]  rd_req;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [DEPTH*DATA_W-1:0]  stage_data;
  logic                     stall;
  logic [NUM_RD*4-1:0]      fwd_sel;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic [31:0]              stall_cnt;
  logic [31:0]              fwd_cnt;

  modport master (
    output en, flush, iss_wen, iss_dst, iss_load, rd_req, rd_data, stage_data,
    input  stall, fwd_sel, fwd_data, stall_cnt, fwd_cnt
  );

  modport slave (
    input  en, flush, iss_wen, iss_dst, iss_load, rd_req, rd_data, stage_data,
    output stall, fwd_sel, fwd_data, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination tags after ID and resolves stall/forwarding per read port.
// Optional stall/forward performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]      ent_v;
  logic [DEPTH-1:0]      ent_load;
  logic [TAG_W-1:0]      ent_dst [DEPTH];

  logic [NUM_RD-1:0]        haz;
  logic [NUM_RD*4-1:0]      sel;
  logic [NUM_RD*DATA_W-1:0] data;
  logic [TAG_W-1:0]         req;
  logic                     found;
  logic                     stall;

  // Youngest matching entry wins; an unready load blocks forwarding and raises a hazard.
  always_comb begin
    haz   = '0;
    sel   = '0;
    data  = '0;
    req   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      req   = bus.rd_req[k*TAG_W +: TAG_W];
      found = 1'b0;
      data[k*DATA_W +: DATA_W] = bus.rd_data[k*DATA_W +: DATA_W];
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && ent_v[i] && ent_dst[i] == req && req != '0) begin
          found = 1'b1;
          if (ent_load[i] && i < LOAD_READY) begin
            haz[k] = 1'b1;
          end else begin
            sel[k*4 +: 4]            = 4'(i + 1);
            data[k*DATA_W +: DATA_W] = bus.stage_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign stall        = (|haz) && !bus.flush;
  assign bus.stall    = stall;
  assign bus.fwd_sel  = sel;
  assign bus.fwd_data = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_v    <= '0;
      ent_load <= '0;
      for (int i = 0; i < DEPTH; i++) ent_dst[i] <= '0;
    end else if (bus.en) begin
      for (int i = 1; i < DEPTH; i++) begin
        ent_v[i]    <= ent_v[i-1];
        ent_load[i] <= ent_load[i-1];
        ent_dst[i]  <= ent_dst[i-1];
      end
      if (stall || bus.flush) begin
        ent_v[0]    <= 1'b0;
        ent_load[0] <= 1'b0;
        ent_dst[0]  <= '0;
      end else begin
        // Writes to $0 are architecturally discarded, so never track them.
        ent_v[0]    <= bus.iss_wen && bus.iss_dst != '0;
        ent_load[0] <= bus.iss_load;
        ent_dst[0]  <= bus.iss_dst;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (bus.en) begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((|sel) && fwd_cnt_q != 32'hFFFF_FFFF) fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.fwd_cnt   = 32'd0;
`endif

endmodule
